keypad_scan_ctrl: RTL and testbench

Scan controller for a ROWS x COLS matrix keypad. It drives one column low at a time and samples the pull-up rows after a settle dwell. It debounces at frame level: a key is reported only after the same single-key result repeats for STABLE_SCANS consecutive frames. It sits between the board keypad pins and the counter/display logic, and replaces per-pin shift-register debouncing for matrix inputs.

---
 rtl/keypad_scan_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad column scanner with frame-level debounce and single-key acceptance.
// Build option: define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid every REPEAT_FRAMES frames while held.

module keypad_scan_ctrl #(
  parameter int COLS          = 4,
  parameter int ROWS          = 4,
  parameter int SETTLE_CYC    = 1000,
  parameter int STABLE_SCANS  = 3,
  parameter int REPEAT_FRAMES = 50,
  localparam int KW           = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_out,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  output logic            key_held,
  output logic            frame_done
);

  localparam int NK  = ROWS*COLS;
  localparam int CIW = $clog2(COLS);
  localparam int DW  = $clog2(SETTLE_CYC);
  localparam int CW  = $clog2(STABLE_SCANS+1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_SCANS);

  typedef enum logic [1:0] {CAND_NONE, CAND_KEY, CAND_MULTI} cand_e;

  logic [ROWS-1:0] sync1_q, sync2_q;
  logic [CIW-1:0]  col_idx_q, col_idx_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [COLS-1:0] col_out_q, col_out_d;
  logic [NK-1:0]   image_q, image_d;
  logic            eval_q, eval_d;
  logic            frame_done_q, frame_done_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;
  logic [KW-1:0]   key_code_q, key_code_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            prev_key_q, prev_key_d;
  logic [KW-1:0]   prev_code_q, prev_code_d;

  cand_e           cand;
  logic [KW-1:0]   cand_code;
  logic [KW:0]     n_closed;
  logic            cand_same;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES+1);
  logic [RW-1:0]   rpt_q, rpt_d;
`else
  logic [31:0]     rpt_cfg_unused;
  assign rpt_cfg_unused = REPEAT_FRAMES;
`endif

  // Column sequencing: image bits are stored active-high (1 = key closed).
  always_comb begin
    dwell_d   = dwell_q + DW'(1);
    col_idx_d = col_idx_q;
    image_d   = image_q;
    eval_d    = 1'b0;
    col_out_d = ~(COLS'(1) << col_idx_q);
    if (dwell_q == DW'(SETTLE_CYC-1)) begin
      dwell_d   = '0;
      col_idx_d = (col_idx_q == CIW'(COLS-1)) ? '0 : col_idx_q + CIW'(1);
      eval_d    = (col_idx_q == CIW'(COLS-1));
      for (int c = 0; c < COLS; c++) begin
        for (int r = 0; r < ROWS; r++) begin
          if (col_idx_q == CIW'(c)) image_d[c*ROWS + r] = ~sync2_q[r];
        end
      end
    end
  end

  always_comb begin
    n_closed  = '0;
    cand_code = '0;
    cand      = CAND_NONE;
    for (int i = 0; i < NK; i++) begin
      if (image_q[i]) begin
        n_closed  = n_closed + (KW+1)'(1);
        cand_code = KW'(i);
      end
    end
    if (n_closed == (KW+1)'(1))    cand = CAND_KEY;
    else if (n_closed != '0)       cand = CAND_MULTI;
    cand_same = (cand == CAND_NONE) ? !prev_key_q
              : (cand == CAND_KEY && prev_key_q && prev_code_q == cand_code);
  end

  always_comb begin
    frame_done_d = 1'b0;
    key_valid_d  = 1'b0;
    key_held_d   = key_held_q;
    key_code_d   = key_code_q;
    cnt_d        = cnt_q;
    prev_key_d   = prev_key_q;
    prev_code_d  = prev_code_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_d        = rpt_q;
`endif
    if (eval_q) begin
      frame_done_d = 1'b1;
      // Ghosted frames break the run but leave the previous candidate in place.
      if (cand == CAND_MULTI) begin
        cnt_d = '0;
      end else if (cand_same) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
      end else begin
        cnt_d       = CW'(1);
        prev_key_d  = (cand == CAND_KEY);
        prev_code_d = cand_code;
      end
      if (cand != CAND_MULTI && cnt_d == CNT_MAX) begin
        if (cand == CAND_KEY && !key_held_q) begin
          key_code_d  = cand_code;
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
        end else if (cand == CAND_NONE) begin
          key_held_d  = 1'b0;
        end
      end
`ifdef KEYPAD_AUTOREPEAT_EN
      if (cand != CAND_MULTI && cnt_d == CNT_MAX && cand == CAND_KEY &&
          key_held_q && cand_code == key_code_q) begin
        if (rpt_q == RW'(REPEAT_FRAMES-1)) begin
          rpt_d       = '0;
          key_valid_d = 1'b1;
        end else begin
          rpt_d = rpt_q + RW'(1);
        end
      end else begin
        rpt_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      col_idx_q    <= '0;
      dwell_q      <= '0;
      col_out_q    <= '1;
      image_q      <= '0;
      eval_q       <= 1'b0;
      frame_done_q <= 1'b0;
      key_valid_q  <= 1'b0;
      key_held_q   <= 1'b0;
      key_code_q   <= '0;
      cnt_q        <= '0;
      prev_key_q   <= 1'b0;
      prev_code_q  <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q        <= '0;
`endif
    end else begin
      sync1_q      <= row_in;
      sync2_q      <= sync1_q;
      col_idx_q    <= col_idx_d;
      dwell_q      <= dwell_d;
      col_out_q    <= col_out_d;
      image_q      <= image_d;
      eval_q       <= eval_d;
      frame_done_q <= frame_done_d;
      key_valid_q  <= key_valid_d;
      key_held_q   <= key_held_d;
      key_code_q   <= key_code_d;
      cnt_q        <= cnt_d;
      prev_key_q   <= prev_key_d;
      prev_code_q  <= prev_code_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q        <= rpt_d;
`endif
    end
  end

  assign col_out    = col_out_q;
  assign key_code   = key_code_q;
  assign key_valid  = key_valid_q;
  assign key_held   = key_held_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: ideal keypad model, per-frame scoreboard, randomized key patterns.
module tb_keypad_scan_ctrl;
  localparam int STABLE = 3;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid, key_held, frame_done;

  logic [15:0] mask;
  logic        force0;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .COLS(4), .ROWS(4), .SETTLE_CYC(4), .STABLE_SCANS(STABLE), .REPEAT_FRAMES(2)
  ) dut (
    .clk(clk), .clr(clr), .row_in(row_in), .col_out(col_out),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
    .frame_done(frame_done)
  );

  // Ideal switch matrix: a closed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = '1;
    if (force0) row_in = '0;
    else begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (!col_out[c] && mask[c*4 + r]) row_in[r] = 1'b0;
    end
  end

  typedef struct packed {
    logic       vld;
    logic       held;
    logic [3:0] code;
  } exp_t;

  exp_t       exp_q[$];
  int         hist[$];
  logic       m_held;
  logic [3:0] m_code;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_held = 1'b0;
    m_code = '0;
    exp_q.delete();
  endtask

  // One frame of the reference: hist holds the non-ghosted results since the last ghosted frame.
  task automatic model_frame(input logic [15:0] m);
    int   n;
    int   cand;
    int   s;
    logic all_same;
    exp_t e;
    n = $countones(m);
    if (n >= 2) hist.delete();
    else begin
      cand = -1;
      for (int i = 0; i < 16; i++) if (m[i]) cand = i;
      hist.push_back(cand);
      if (hist.size() > STABLE) void'(hist.pop_front());
    end
    e.vld = 1'b0;
    if (hist.size() == STABLE) begin
      all_same = 1'b1;
      for (int i = 1; i < STABLE; i++) if (hist[i] != hist[0]) all_same = 1'b0;
      if (all_same) begin
        s = hist[0];
        if (s >= 0 && !m_held) begin
          e.vld  = 1'b1;
          m_held = 1'b1;
          m_code = 4'(s);
        end else if (s < 0) begin
          m_held = 1'b0;
        end
      end
    end
    e.held = m_held;
    e.code = m_code;
    exp_q.push_back(e);
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 40);
    chk("frame_timeout", frame_done, 1);
  endtask

  task automatic next_frame(input logic [15:0] m);
    mask = m;
    model_frame(m);
    wait_frame();
  endtask

  task automatic run(input logic [15:0] m, input int frames);
    for (int k = 0; k < frames; k++) next_frame(m);
  endtask

  // Monitor: compares every frame evaluation against the scoreboard.
  int cyc = 0;
  int last_fd = -1;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (clr) last_fd = -1;
    else begin
      if (key_valid) chk("valid_without_frame_done", frame_done, 1);
      if (frame_done) begin
        if (last_fd >= 0) chk("frame_period", cyc - last_fd, 16);
        last_fd = cyc;
        if (exp_q.size() == 0) chk("frame_without_expectation", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("key_valid", key_valid, e.vld);
          chk("key_held", key_held, e.held);
          chk("key_code", key_code, e.code);
        end
      end
    end
  end

  initial begin
    int         cyc0;
    int         a, b, kind, nf;
    logic [15:0] m;
    clr = 1'b1; force0 = 1'b1; mask = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_col_out", col_out, 4'b1111);
    chk("reset_key_valid", key_valid, 0);
    chk("reset_key_held", key_held, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_key_code", key_code, 0);

    model_frame(mask);
    clr = 1'b0; force0 = 1'b0;
    @(negedge clk);
    chk("col0_after_release", col_out, 4'b1110);
    repeat (4) @(negedge clk);
    chk("col1_after_dwell", col_out, 4'b1101);
    cyc0 = 5;
    while (!frame_done && cyc0 < 40) begin
      @(negedge clk);
      cyc0++;
    end
    chk("first_frame_done_cycle", cyc0, 17);

    // Clean press of code 9, then release.
    run(16'h0200, 5);
    run(16'h0000, 4);
    // Bounce for four frames, then steady.
    for (int k = 0; k < 4; k++) next_frame((k % 2 == 0) ? 16'h0200 : 16'h0000);
    run(16'h0200, 5);
    run(16'h0000, 4);
    // Ghosting: codes 0 and 5, then only 5, then ghost again while 5 is held.
    run(16'h0021, 4);
    run(16'h0020, 4);
    run(16'h0021, 3);
    run(16'h0020, 3);
    run(16'h0000, 4);
    // Re-press code 15, then reset mid-frame while it is held.
    run(16'h8000, 4);
    repeat (5) @(negedge clk);
    clr = 1'b1;
    model_reset();
    @(negedge clk);
    chk("midreset_key_held", key_held, 0);
    chk("midreset_col_out", col_out, 4'b1111);
    chk("midreset_key_valid", key_valid, 0);
    model_frame(mask);
    clr = 1'b0;
    @(negedge clk);
    chk("midreset_restart_col0", col_out, 4'b1110);
    wait_frame();
    run(mask, 4);
    run(16'h0000, 4);

    // Randomized key patterns held for random frame counts.
    for (int blk = 0; blk < 25; blk++) begin
      kind = $urandom_range(0, 3);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      m = '0;
      if (kind == 1 || kind == 2) m[a] = 1'b1;
      else if (kind == 3) begin
        m[a] = 1'b1;
        m[b] = 1'b1;
      end
      nf = $urandom_range(1, 5);
      run(m, nf);
    end
    run(16'h0000, 4);

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
